// File: rtl/motion_executor.sv
// motion_executor
// ---------------
// Turns one motion command from the decision stage into wheel drive signals.
// The block latches the command and runs it for dur x TICK_DIV clock cycles.
// During the run the wheel enables are PWM-modulated. When the run ends
// normally, cmd_done pulses for one cycle so that upstream can advance.
//
// Command interface (level-based, no valid/ready pair):
//   A command counts as "valid" when its type is not STOP and motion_speed
//   is not 0. In IDLE, a valid command is latched at the next edge. During
//   RUN the latched copy is used and later input changes are ignored. The one
//   exception is a STOP type, which aborts the run with no cmd_done. A valid
//   command that is still present after DONE is latched again. To prevent
//   that repeat, upstream must change the command or pause during the
//   cmd_done cycle.
//
// Parameters:
//   TICK_DIV  clk cycles per duration tick (>= 2)
//   TICK_W    prescaler width, 2**TICK_W >= TICK_DIV
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   motion_command  [9:8] type (00 stop, 01 fwd, 10 left, 11 right),
//                   [7:0] duration in ticks
//   motion_speed    duty in eighths (0..7)
//   left_en/right_en    wheel PWM enables
//   left_dir/right_dir  wheel directions (1 = forward), 0 outside RUN
//   busy            high while in RUN
//   cmd_done        one-cycle pulse on normal completion
//   dbg_state       current FSM state (0 IDLE, 1 RUN, 2 DONE)
module motion_executor #(
  parameter int TICK_DIV = 1000,
  parameter int TICK_W   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] motion_command,
  input  logic [2:0] motion_speed,
  output logic       left_en,
  output logic       right_en,
  output logic       left_dir,
  output logic       right_dir,
  output logic       busy,
  output logic       cmd_done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] TYPE_STOP  = 2'b00;
  localparam logic [1:0] TYPE_LEFT  = 2'b10;
  localparam logic [1:0] TYPE_RIGHT = 2'b11;
  localparam logic [TICK_W-1:0] PRE_MAX = TICK_W'(TICK_DIV - 1);

  state_t            r_state,  w_state_nx;
  logic [1:0]        r_type,   w_type_nx;
  logic [7:0]        r_dur,    w_dur_nx;
  logic [2:0]        r_speed,  w_speed_nx;
  logic [TICK_W-1:0] r_pre,    w_pre_nx;
  logic [2:0]        r_pwm,    w_pwm_nx;
  logic              r_en,     w_en_nx;
  logic              r_ldir,   w_ldir_nx;
  logic              r_rdir,   w_rdir_nx;
  logic              w_run_nx;

  always_comb begin
    w_state_nx = r_state;
    w_type_nx  = r_type;
    w_dur_nx   = r_dur;
    w_speed_nx = r_speed;
    w_pre_nx   = r_pre;
    w_pwm_nx   = r_pwm + 3'd1;
    case (r_state)
      S_IDLE: begin
        if (motion_command[9:8] != TYPE_STOP && motion_speed != 3'd0) begin
          w_type_nx  = motion_command[9:8];
          w_dur_nx   = motion_command[7:0];
          w_speed_nx = motion_speed;
          w_pre_nx   = '0;
          w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (motion_command[9:8] == TYPE_STOP) begin
          // Upstream pause: abort without completion.
          w_state_nx = S_IDLE;
        end else if (r_dur == 8'd0) begin
          // Zero-length command: finish immediately and do not drive the wheels.
          w_state_nx = S_DONE;
        end else if (r_pre == PRE_MAX) begin
          w_pre_nx = '0;
          w_dur_nx = r_dur - 8'd1;
          if (r_dur == 8'd1) w_state_nx = S_DONE;
        end else begin
          w_pre_nx = r_pre + 1'b1;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase

    // Wheel outputs are computed from next-state values and then registered.
    // This makes them glitch-free and lines them up with the state register.
    w_run_nx  = (w_state_nx == S_RUN);
    w_en_nx   = w_run_nx && (w_dur_nx != 8'd0) && (w_pwm_nx < w_speed_nx);
    w_ldir_nx = w_run_nx && (w_type_nx != TYPE_LEFT);
    w_rdir_nx = w_run_nx && (w_type_nx != TYPE_RIGHT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_type  <= 2'd0;
      r_dur   <= 8'd0;
      r_speed <= 3'd0;
      r_pre   <= '0;
      r_pwm   <= 3'd0;
      r_en    <= 1'b0;
      r_ldir  <= 1'b0;
      r_rdir  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_type  <= w_type_nx;
      r_dur   <= w_dur_nx;
      r_speed <= w_speed_nx;
      r_pre   <= w_pre_nx;
      r_pwm   <= w_pwm_nx;
      r_en    <= w_en_nx;
      r_ldir  <= w_ldir_nx;
      r_rdir  <= w_rdir_nx;
    end
  end

  assign left_en   = r_en;
  assign right_en  = r_en;
  assign left_dir  = r_ldir;
  assign right_dir = r_rdir;
  assign busy      = (r_state == S_RUN);
  assign cmd_done  = (r_state == S_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_motion_executor.sv
// Directed bench for motion_executor with TICK_DIV = 4.
// The output vector is {busy, cmd_done, left_en, right_en, left_dir, right_dir}.
// The plan_run task queues the expected vector for each cycle, and drain_q
// compares one queued vector per cycle at the falling edge.
module tb_motion_executor;

  logic       clk;
  logic       rst;
  logic [9:0] motion_command;
  logic [2:0] motion_speed;
  logic       left_en, right_en, left_dir, right_dir, busy, cmd_done;
  logic [1:0] dbg_state;

  logic [5:0] exp_q[$];
  logic [2:0] pwm_model;
  int         n_tests;
  int         n_fail;

  motion_executor #(.TICK_DIV(4), .TICK_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .motion_command (motion_command),
    .motion_speed   (motion_speed),
    .left_en        (left_en),
    .right_en       (right_en),
    .left_dir       (left_dir),
    .right_dir      (right_dir),
    .busy           (busy),
    .cmd_done       (cmd_done),
    .dbg_state      (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running PWM phase model: cleared by reset, +1 on every rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) pwm_model <= 3'd0;
    else     pwm_model <= pwm_model + 3'd1;
  end

  function automatic logic [5:0] get_out();
    return {busy, cmd_done, left_en, right_en, left_dir, right_dir};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Queue n_idle all-zero cycles, then n_run RUN cycles, then (optionally)
  // one DONE cycle. The task must be called at the falling edge just before
  // the edge that latches the command.
  task automatic plan_run(input int n_idle, input logic [1:0] typ, input logic [7:0] dur,
                          input logic [2:0] spd, input int n_run, input bit with_done);
    int p;
    p = int'(pwm_model);
    for (int i = 1; i <= n_idle; i++) exp_q.push_back(6'b000000);
    for (int j = 1; j <= n_run; j++) begin
      logic [2:0] pw;
      logic       en;
      pw = 3'((p + n_idle + j) % 8);
      en = (dur != 8'd0) && (pw < spd);
      exp_q.push_back({1'b1, 1'b0, en, en, typ != 2'b10, typ != 2'b11});
    end
    if (with_done) exp_q.push_back(6'b010000);
  endtask

  task automatic drain_q(input string tag);
    logic [5:0] e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq(tag, 32'(get_out()), 32'(e));
    end
  endtask

  task automatic drive_cmd(input logic [9:0] cmd, input logic [2:0] spd);
    motion_command = cmd;
    motion_speed   = spd;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive_cmd(10'd0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", 32'(get_out()), 32'd0);
    check_eq("reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: reset in the middle of a run
    drive_cmd(10'b01_00000011, 3'd7);
    plan_run(0, 2'b01, 8'd3, 3'd7, 5, 1'b0);
    drain_q("t1_pre_reset");
    rst = 1'b1;
    #1;
    check_eq("t1_async_outputs", 32'(get_out()), 32'd0);
    check_eq("t1_async_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("t1_idle_after_release", 32'(dbg_state), 32'd0);
    plan_run(0, 2'b01, 8'd3, 3'd7, 12, 1'b1);
    drain_q("t1_relatch");
    drive_cmd(10'd0, 3'd0);
    plan_run(2, 2'b00, 8'd0, 3'd0, 0, 1'b0);
    drain_q("t1_idle");

    // 2: forward, 3 ticks, half duty, then pause in the done cycle
    drive_cmd(10'b01_00000011, 3'd4);
    plan_run(0, 2'b01, 8'd3, 3'd4, 12, 1'b1);
    drain_q("t2_fwd");
    drive_cmd(10'b00_00000011, 3'd4);
    plan_run(3, 2'b00, 8'd0, 3'd0, 0, 1'b0);
    drain_q("t2_stay_idle");
    check_eq("t2_state_idle", 32'(dbg_state), 32'd0);

    // 3: turn left, then turn right queued in the done cycle
    drive_cmd(10'b10_00000010, 3'd7);
    plan_run(0, 2'b10, 8'd2, 3'd7, 8, 1'b1);
    drain_q("t3_left");
    drive_cmd(10'b11_00000001, 3'd7);
    plan_run(1, 2'b11, 8'd1, 3'd7, 4, 1'b1);
    drain_q("t3_right");
    drive_cmd(10'd0, 3'd0);
    plan_run(2, 2'b00, 8'd0, 3'd0, 0, 1'b0);
    drain_q("t3_idle");

    // 4: abort after 5 RUN cycles
    drive_cmd(10'b01_00001000, 3'd3);
    plan_run(0, 2'b01, 8'd8, 3'd3, 5, 1'b0);
    drain_q("t4_run");
    drive_cmd(10'b00_10101010, 3'd3);
    plan_run(3, 2'b00, 8'd0, 3'd0, 0, 1'b0);
    drain_q("t4_abort");
    check_eq("t4_state_idle", 32'(dbg_state), 32'd0);

    // 5: zero duration, then speed 0 never starts
    drive_cmd(10'b01_00000000, 3'd5);
    plan_run(0, 2'b01, 8'd0, 3'd5, 1, 1'b1);
    drain_q("t5_zero_dur");
    drive_cmd(10'b01_00000011, 3'd0);
    plan_run(4, 2'b00, 8'd0, 3'd0, 0, 1'b0);
    drain_q("t5_speed0");
    check_eq("t5_state_idle", 32'(dbg_state), 32'd0);

    // 6: held command repeats; then maximum duration
    drive_cmd(10'b11_00000010, 3'd2);
    plan_run(0, 2'b11, 8'd2, 3'd2, 8, 1'b1);
    plan_run(1, 2'b11, 8'd2, 3'd2, 8, 1'b1);
    // The second plan_run assumed it starts right after the first run. Rebuild
    // the queue so that each run uses its own PWM phase: the second run
    // starts 10 edges after the first (8 RUN + 1 DONE + 1 IDLE).
    exp_q.delete();
    plan_run(0, 2'b11, 8'd2, 3'd2, 8, 1'b1);
    begin
      int p;
      p = int'(pwm_model);
      exp_q.push_back(6'b000000);
      for (int j = 1; j <= 8; j++) begin
        logic [2:0] pw;
        logic       en;
        pw = 3'((p + 10 + j) % 8);
        en = (pw < 3'd2);
        exp_q.push_back({1'b1, 1'b0, en, en, 1'b1, 1'b0});
      end
      exp_q.push_back(6'b010000);
    end
    drain_q("t6_repeat");
    drive_cmd(10'd0, 3'd0);
    plan_run(1, 2'b00, 8'd0, 3'd0, 0, 1'b0);
    drain_q("t6_idle");

    drive_cmd(10'b01_11111111, 3'd1);
    plan_run(0, 2'b01, 8'd255, 3'd1, 1020, 1'b1);
    drain_q("t6_dur255");
    drive_cmd(10'd0, 3'd0);
    plan_run(2, 2'b00, 8'd0, 3'd0, 0, 1'b0);
    drain_q("t6_final_idle");
    check_eq("t6_state_idle", 32'(dbg_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motion_executor.md
Name: motion_executor

Overview:
- Consumes the 10-bit motion command and 3-bit motion speed produced by the movement decision multiplexer and turns them into wheel drive signals.
- Latches one command, runs it for the commanded number of timebase ticks with PWM-modulated wheel enables, then pulses cmd_done so upstream movement logic can advance.
- Sits between the decision stage and the wheel driver pins.

Parameters:
- TICK_DIV, 1000, clk cycles per duration tick (minimum 2).
- TICK_W, 10, prescaler counter width; must satisfy 2^TICK_W >= TICK_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- motion_command  input  10  [9:8] type (00 STOP/pause, 01 FORWARD, 10 TURN_LEFT, 11 TURN_RIGHT); [7:0] duration in ticks.
- motion_speed  input  3  duty in eighths (0..7).
- left_en  output  1  left wheel PWM enable.
- right_en  output  1  right wheel PWM enable.
- left_dir  output  1  left wheel direction (1 = forward).
- right_dir  output  1  right wheel direction (1 = forward).
- busy  output  1  high while in RUN.
- cmd_done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset: one clock, rst asynchronous active-high. While rst is high: state=IDLE; prescaler, PWM counter, tick counter and latched registers are 0; all outputs are 0.
- Registers: type_q[1:0], dur_q[7:0], speed_q[2:0], prescaler[TICK_W-1:0], pwm_cnt[2:0].
- pwm_cnt is free-running: it increments every clk and wraps 7->0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If motion_command[9:8] != 00 and motion_speed != 0 at a clk edge, latch type_q, dur_q and speed_q, clear prescaler, and go to RUN.
  - Otherwise stay in IDLE. STOP type or speed 0 is never started.
- RUN:
  - busy=1. Prescaler counts 0..TICK_DIV-1. When it reaches TICK_DIV-1, it wraps to 0 and dur_q decrements.
  - When dur_q==1 and the prescaler wraps, go to DONE.
  - If dur_q==0 on RUN entry, go to DONE on the next edge. No wheel enable is asserted in that case.
  - Abort: if motion_command[9:8]==00 (upstream pause) during RUN, go to IDLE on the next edge with no cmd_done. Type or duration changes other than STOP during RUN are ignored because the command is latched.
- DONE: cmd_done=1 for exactly one cycle, busy=0, then IDLE.
- Back-to-back commands: if a valid command is still present in IDLE, it is re-latched the cycle after DONE. Upstream must change or pause the command within the cmd_done cycle to avoid a repeat.
- Wheel enables:
  - left_en = right_en = (state==RUN) && (pwm_cnt < speed_q). These are registered from next-state values so they are glitch-free.
  - speed_q=7 gives 7/8 duty. Outputs are 0 outside RUN.
- Directions, valid in RUN and 0 otherwise:
  - FORWARD: left_dir=1, right_dir=1.
  - TURN_LEFT: left_dir=0, right_dir=1.
  - TURN_RIGHT: left_dir=1, right_dir=0.
- Latency:
  - Command present at edge N gives busy=1 after edge N.
  - Nominal run length is dur×TICK_DIV cycles in RUN, then 1 DONE cycle.
- Width rules: dur 255 is the maximum. dur_q never underflows because the decrement happens only when dur_q>=1. The prescaler never exceeds TICK_DIV-1.
- Reset mid-RUN: all outputs drop to 0 immediately (asynchronous); no cmd_done.

Test Plan (TICK_DIV=4):
1. Reset asserted mid-RUN with command 01_00000011, speed 7 -> all outputs 0 immediately; after release, FSM is in IDLE and the command re-latches on the first edge.
2. Command 01_00000011, speed 4 -> busy for 12 cycles; left_en/right_en high exactly when pwm_cnt<4; both dirs 1; single cmd_done pulse; upstream then drives 00 and the FSM stays IDLE.
3. Command 10_00000010, speed 7 -> left_dir=0, right_dir=1 for 8 RUN cycles; enables low only when pwm_cnt==7; then 11_00000001 gives left_dir=1, right_dir=0 for 4 cycles.
4. Command 01_00001000, speed 3; drive 00_xxxxxxxx after 5 RUN cycles -> busy=0 next cycle, enables 0, no cmd_done.
5. Command 01_00000000, speed 5 -> 1 RUN cycle with enables 0, then cmd_done; speed 0 with type 01 -> never leaves IDLE.
6. Command held constant 11_00000010, speed 2 -> two consecutive runs separated by exactly one DONE cycle and one IDLE latch edge; duration 255 run lasts 1020 cycles without underflow.
